// File: rtl/fsm_cmd_pkg.sv
// fsm_cmd_pkg: state/error encodings and command codes shared by the command issuer
package fsm_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE     = 2'b00,
        TIMEOUT  = 2'b01,
        BAD_MODE = 2'b10,
        BAD_ECHO = 2'b11
    } err_code_t;

    localparam logic [2:0] CMD_IDLE = 3'h0;
    localparam logic [2:0] CMD_M1   = 3'h5;
    localparam logic [2:0] CMD_M2   = 3'h4;
    localparam logic [2:0] CMD_M3   = 3'h3;

    function automatic logic [2:0] mode_cmd(input logic [1:0] m);
        return m == 2'd1 ? CMD_M1 : m == 2'd2 ? CMD_M2 : m == 2'd3 ? CMD_M3 : CMD_IDLE;
    endfunction

endpackage

// File: rtl/fsm_cmd_timer.sv
// fsm_cmd_timer: clearable 8-bit echo-wait counter with terminal-count flag
module fsm_cmd_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        count <= (rst || clr) ? 8'd0 : count + 8'd1;
    end

    assign tc = count == 8'(TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/fsm_cmd_issuer.sv
// fsm_cmd_issuer: issues a mode command, waits for the echo, retries on timeout.
// Define FSM_CMD_ISSUER_STATE_GUARD_EN to flag and report illegal state encodings.
module fsm_cmd_issuer
    import fsm_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    output logic [2:0] cmd_out,
    output logic       cmd_valid,
    input  logic [2:0] status_in,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       illegal_state
);

    localparam logic [1:0] MAX_R = 2'(MAX_RETRY);

    state_t     state;
    logic [1:0] mode;
    logic [1:0] retry;
    logic       tc;

    fsm_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state != WAIT),
        .tc (tc)
    );

    assign req_ready = (state == IDLE) && !rst;

    // Outputs are registered on the transition into the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode      <= 2'd0;
            retry     <= 2'd0;
            cmd_valid <= 1'b0;
            cmd_out   <= CMD_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= NONE;
`ifdef FSM_CMD_ISSUER_STATE_GUARD_EN
            illegal_state <= 1'b0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            cmd_out   <= CMD_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    if (req_mode == 2'd0) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= BAD_MODE;
                    end else begin
                        state     <= ISSUE;
                        mode      <= req_mode;
                        retry     <= 2'd0;
                        err_code  <= NONE;
                        cmd_valid <= 1'b1;
                        cmd_out   <= mode_cmd(req_mode);
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (status_in == {1'b1, mode}) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (!status_in[2]) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= BAD_ECHO;
                    end else if (tc && retry < MAX_R) begin
                        state     <= ISSUE;
                        retry     <= retry + 2'd1;
                        cmd_valid <= 1'b1;
                        cmd_out   <= mode_cmd(mode);
                    end else if (tc) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        err_code <= TIMEOUT;
                    end
                end
                DONE, ERR: state <= IDLE;
                default: begin
                    state <= IDLE;
`ifdef FSM_CMD_ISSUER_STATE_GUARD_EN
                    illegal_state <= 1'b1;
                    err           <= 1'b1;
                    err_code      <= BAD_ECHO;
`endif
                end
            endcase
        end
    end

`ifndef FSM_CMD_ISSUER_STATE_GUARD_EN
    assign illegal_state = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_cmd_issuer.sv
// tb_fsm_cmd_issuer: scoreboard bench for the mode command issuer
module tb_fsm_cmd_issuer;
    import fsm_cmd_pkg::*;

    typedef struct packed {
        logic       d;
        logic       e;
        logic [1:0] code;
    } out_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_mode;
    logic [2:0] cmd_out;
    logic       cmd_valid;
    logic [2:0] status_in;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic       illegal_state;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] exp_cmd[$];
    out_t       exp_out[$];
    logic [2:0] ec;
    out_t       eo;

    fsm_cmd_issuer #(.TIMEOUT_CYCLES(16), .MAX_RETRY(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mode     (req_mode),
        .cmd_out      (cmd_out),
        .cmd_valid    (cmd_valid),
        .status_in    (status_in),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .illegal_state(illegal_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: every command and every done/err pulse must match the next expectation.
    always @(negedge clk) begin
        if (cmd_valid) begin
            vectors++;
            if (exp_cmd.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_unexpected: got cmd_out=%h, none expected", cmd_out);
            end else begin
                ec = exp_cmd.pop_front();
                if (cmd_out !== ec) begin
                    miscompares++;
                    $display("FAIL cmd_code: got %h, expected %h", cmd_out, ec);
                end
            end
        end
        if (done || err) begin
            vectors++;
            if (exp_out.size() == 0) begin
                miscompares++;
                $display("FAIL outcome_unexpected: got done=%b err=%b code=%b", done, err, err_code);
            end else begin
                eo = exp_out.pop_front();
                if ({done, err, err_code} !== eo) begin
                    miscompares++;
                    $display("FAIL outcome: got done=%b err=%b code=%b, expected done=%b err=%b code=%b",
                             done, err, err_code, eo.d, eo.e, eo.code);
                end
            end
        end
    end

    task automatic accept(input logic [1:0] m);
        for (int i = 0; i < 60 && !req_ready; i++) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: got req_ready=%b, expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_mode  = m;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b, expected 0", req_ready);
        end
        vectors++;
        if ({cmd_valid, cmd_out, done, err, err_code, illegal_state} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, expected 0", {cmd_valid, cmd_out, done, err, err_code, illegal_state});
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b, expected 1", req_ready);
        end
    endtask

    task automatic test_mode2_echo;
        exp_cmd.push_back(CMD_M2);
        exp_out.push_back({1'b1, 1'b0, 2'b00});
        accept(2'd2);
        vectors++;
        if (cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mode2_cmd_latency: got cmd_valid=%b, expected 1", cmd_valid);
        end
        @(negedge clk);
        vectors++;
        if ({cmd_valid, cmd_out} !== 4'b0) begin
            miscompares++;
            $display("FAIL mode2_wait_idle: got cmd_valid=%b cmd_out=%h, expected 0/0", cmd_valid, cmd_out);
        end
        @(negedge clk);
        status_in = 3'b110;
        @(negedge clk);
        status_in = 3'b100;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL mode2_done: got done=%b, expected 1", done);
        end
        @(negedge clk);
        vectors++;
        if ({done, err_code} !== 3'b000) begin
            miscompares++;
            $display("FAIL mode2_after: got done=%b err_code=%b, expected 0/00", done, err_code);
        end
    endtask

    task automatic test_min_latency;
        exp_cmd.push_back(CMD_M1);
        exp_out.push_back({1'b1, 1'b0, 2'b00});
        accept(2'd1);
        status_in = 3'b101;
        repeat (2) @(negedge clk);
        status_in = 3'b100;
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL min_latency_done: got done=%b, expected 1 three cycles after accept", done);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int n = 0;
        repeat (3) exp_cmd.push_back(CMD_M3);
        exp_out.push_back({1'b0, 1'b1, 2'b01});
        accept(2'd3);
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n !== 51) begin
            miscompares++;
            $display("FAIL timeout_cycles: got err after %0d cycles, expected 51", n);
        end
        @(negedge clk);
        vectors++;
        if ({err, err_code} !== 3'b001) begin
            miscompares++;
            $display("FAIL timeout_code_hold: got err=%b err_code=%b, expected 0/01", err, err_code);
        end
        vectors++;
        if (exp_cmd.size() !== 0) begin
            miscompares++;
            $display("FAIL timeout_issues: got %0d commands missing, expected 0", exp_cmd.size());
        end
    endtask

    task automatic test_bad_mode;
        exp_out.push_back({1'b0, 1'b1, 2'b10});
        accept(2'd0);
        vectors++;
        if ({err, cmd_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL bad_mode_err: got err=%b cmd_valid=%b, expected 1/0", err, cmd_valid);
        end
        @(negedge clk);
        vectors++;
        if (err_code !== 2'b10) begin
            miscompares++;
            $display("FAIL bad_mode_code_hold: got %b, expected 10", err_code);
        end
    endtask

    task automatic test_bad_echo;
        exp_cmd.push_back(CMD_M1);
        exp_out.push_back({1'b0, 1'b1, 2'b11});
        accept(2'd1);
        status_in = 3'b001;
        repeat (2) @(negedge clk);
        status_in = 3'b100;
        vectors++;
        if ({err, err_code} !== 3'b111) begin
            miscompares++;
            $display("FAIL bad_echo: got err=%b err_code=%b, expected 1/11", err, err_code);
        end
        @(negedge clk);
    endtask

    task automatic test_terminal_echo;
        exp_cmd.push_back(CMD_M1);
        exp_out.push_back({1'b1, 1'b0, 2'b00});
        accept(2'd1);
        repeat (16) @(negedge clk);
        status_in = 3'b101;
        @(negedge clk);
        status_in = 3'b100;
        vectors++;
        if ({done, cmd_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL terminal_echo: got done=%b cmd_valid=%b, expected 1/0", done, cmd_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        repeat (2) begin
            exp_cmd.push_back(CMD_M2);
            exp_out.push_back({1'b1, 1'b0, 2'b00});
        end
        status_in = 3'b110;
        req_mode  = 2'd2;
        req_valid = 1'b1;
        for (int i = 0; i < 40 && exp_out.size() != 0; i++) @(negedge clk);
        req_valid = 1'b0;
        status_in = 3'b100;
        vectors++;
        if (exp_out.size() + exp_cmd.size() !== 0) begin
            miscompares++;
            $display("FAIL back_to_back: got %0d expectations unmet, expected 0", exp_out.size() + exp_cmd.size());
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_idle: got req_ready=%b, expected 1", req_ready);
        end
    endtask

    task automatic test_reset_mid;
        exp_cmd.push_back(CMD_M2);
        accept(2'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req_ready, cmd_valid, cmd_out, done, err, err_code, illegal_state} !== 10'b0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %b, expected 0",
                     {req_ready, cmd_valid, cmd_out, done, err, err_code, illegal_state});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_ready: got %b, expected 1", req_ready);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_illegal;
`ifdef FSM_CMD_ISSUER_STATE_GUARD_EN
        exp_out.push_back({1'b0, 1'b1, 2'b11});
`endif
        force dut.state = state_t'(3'b111);
        #1 release dut.state;
        @(negedge clk);
        vectors++;
        if (dut.state !== IDLE) begin
            miscompares++;
            $display("FAIL illegal_recover: got state=%b, expected 000", dut.state);
        end
`ifdef FSM_CMD_ISSUER_STATE_GUARD_EN
        vectors++;
        if ({illegal_state, err, err_code} !== 4'b1111) begin
            miscompares++;
            $display("FAIL illegal_guard: got illegal=%b err=%b code=%b, expected 1/1/11", illegal_state, err, err_code);
        end
`else
        vectors++;
        if ({illegal_state, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL illegal_noguard: got illegal=%b err=%b, expected 0/0", illegal_state, err);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        #300000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 2'd0;
        status_in = 3'b100;
        @(negedge clk);
        test_reset;
        test_mode2_echo;
        test_min_latency;
        test_timeout;
        test_bad_mode;
        test_bad_echo;
        test_terminal_echo;
        test_back_to_back;
        test_reset_mid;
        test_illegal;
        vectors++;
        if (exp_cmd.size() + exp_out.size() !== 0) begin
            miscompares++;
            $display("FAIL final_queues: got %0d pending, expected 0", exp_cmd.size() + exp_out.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
